// File: rtl/llc_input_arbiter_pkg.sv
// Shared types and constants for the LLC input arbiter.
// Source encoding matches the decode stage's view of the input channels.
package llc_input_arbiter_pkg;

  // Default number of consecutive req_in grants tolerated while DMA waits
  localparam int LLC_ARB_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    SRC_RST = 2'd0,
    SRC_RSP = 2'd1,
    SRC_REQ = 2'd2,
    SRC_DMA = 2'd3
  } llc_arb_src_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } llc_arb_state_t;

endpackage

// File: rtl/llc_arb_starve_ctr.sv
// Saturating counter of consecutive req_in grants made while DMA was waiting.
// at_limit flags that DMA must be promoted ahead of req_in.
module llc_arb_starve_ctr #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  // Clear wins over increment; count holds once it reaches the limit
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != W'(LIMIT))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_limit = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/llc_input_arbiter.sv
// LLC input arbiter: grants one of rst_tb / rsp_in / req_in / dma_req_in per
// pipeline operation and holds the grant until op_done.
// Optional DMA anti-starvation promotion is built when LLC_ARB_STARVE_EN is defined.
module llc_input_arbiter
  import llc_input_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = LLC_ARB_STARVE_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       llc_rst_tb_valid,
  output logic       llc_rst_tb_ready,
  input  logic       llc_rsp_in_valid,
  output logic       llc_rsp_in_ready,
  input  logic       llc_req_in_valid,
  output logic       llc_req_in_ready,
  input  logic       llc_dma_req_in_valid,
  output logic       llc_dma_req_in_ready,
  input  logic       set_conflict,
  input  logic       evict_stall,
  input  logic       mshr_full,
  input  logic       decode_ready,
  input  logic       op_done,
  output logic       grant_valid,
  output logic [1:0] grant_src,
  output logic       starve_active
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  llc_arb_state_t state_q, state_d;
  llc_arb_src_t   grant_src_q, grant_src_d;
  llc_arb_src_t   win_src;
  logic           has_win;
  logic           req_ok;
  logic           grant_fire;
  logic           promote_dma;

`ifdef LLC_ARB_STARVE_EN
  logic starve_inc;
  logic starve_clr;

  assign starve_inc = grant_fire && (win_src == SRC_REQ) && llc_dma_req_in_valid;
  assign starve_clr = (grant_fire && (win_src == SRC_DMA)) ||
                      ((state_q == ST_IDLE) && !llc_dma_req_in_valid);

  llc_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_limit(promote_dma)
  );
`else
  assign promote_dma = 1'b0;
`endif

  assign starve_active = promote_dma;

  // Fixed-priority pick among eligible sources, DMA promoted above req when starved
  always_comb begin
    has_win = 1'b1;
    win_src = SRC_RST;
    req_ok  = llc_req_in_valid && !set_conflict && !evict_stall && !mshr_full;
    if (llc_rst_tb_valid) begin
      win_src = SRC_RST;
    end else if (llc_rsp_in_valid) begin
      win_src = SRC_RSP;
    end else if (promote_dma && llc_dma_req_in_valid) begin
      win_src = SRC_DMA;
    end else if (req_ok) begin
      win_src = SRC_REQ;
    end else if (llc_dma_req_in_valid) begin
      win_src = SRC_DMA;
    end else begin
      has_win = 1'b0;
    end
  end

  assign grant_fire = (state_q == ST_IDLE) && decode_ready && has_win && !rst;

  // Next-state and held-grant logic for the IDLE/BUSY handshake
  always_comb begin
    state_d     = state_q;
    grant_src_d = grant_src_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          state_d     = ST_BUSY;
          grant_src_d = win_src;
        end
      end
      ST_BUSY: begin
        if (op_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and granted-source registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_src_q <= SRC_RST;
    end else begin
      state_q     <= state_d;
      grant_src_q <= grant_src_d;
    end
  end

  assign llc_rst_tb_ready     = grant_fire && (win_src == SRC_RST);
  assign llc_rsp_in_ready     = grant_fire && (win_src == SRC_RSP);
  assign llc_req_in_ready     = grant_fire && (win_src == SRC_REQ);
  assign llc_dma_req_in_ready = grant_fire && (win_src == SRC_DMA);
  assign grant_valid          = (state_q == ST_BUSY);
  assign grant_src            = grant_src_q;

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Testbench for llc_input_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model. Honours LLC_ARB_STARVE_EN.
module tb_llc_input_arbiter;

  localparam int LIMIT = 2;
`ifdef LLC_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_tb_v = 1'b0, rsp_v = 1'b0, req_v = 1'b0, dma_v = 1'b0;
  logic rst_tb_r, rsp_r, req_r, dma_r;
  logic set_conflict = 1'b0, evict_stall = 1'b0, mshr_full = 1'b0;
  logic decode_ready = 1'b0, op_done = 1'b0;
  logic grant_valid, starve_active;
  logic [1:0] grant_src;
  logic [3:0] rdy;

  int total = 0;
  int bad = 0;

  // model state: outstanding grant, its source, consecutive req-over-dma streak
  bit       m_busy;
  logic [1:0] m_src;
  int       m_streak;

  assign rdy = {dma_r, req_r, rsp_r, rst_tb_r};

  always #5 clk = ~clk;

  llc_input_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .llc_rst_tb_valid    (rst_tb_v),
    .llc_rst_tb_ready    (rst_tb_r),
    .llc_rsp_in_valid    (rsp_v),
    .llc_rsp_in_ready    (rsp_r),
    .llc_req_in_valid    (req_v),
    .llc_req_in_ready    (req_r),
    .llc_dma_req_in_valid(dma_v),
    .llc_dma_req_in_ready(dma_r),
    .set_conflict        (set_conflict),
    .evict_stall         (evict_stall),
    .mshr_full           (mshr_full),
    .decode_ready        (decode_ready),
    .op_done             (op_done),
    .grant_valid         (grant_valid),
    .grant_src           (grant_src),
    .starve_active       (starve_active)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic dr, input logic od);
    {dma_v, req_v, rsp_v, rst_tb_v} = v;
    decode_ready = dr;
    op_done      = od;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    {set_conflict, evict_stall, mshr_full} = 3'b000;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    m_busy = 1'b0; m_src = 2'd0; m_streak = 0;
  endtask

  // Expected winner from the priority rules; -1 when nothing may be granted
  function automatic int model_winner();
    bit req_elig;
    bit promote;
    if (rst || m_busy || !decode_ready) return -1;
    req_elig = req_v && !set_conflict && !evict_stall && !mshr_full;
    promote  = STARVE_EN && (m_streak >= LIMIT);
    if (rst_tb_v) return 0;
    if (rsp_v) return 1;
    if (promote && dma_v) return 3;
    if (req_elig) return 2;
    if (dma_v) return 3;
    return -1;
  endfunction

  task automatic model_clock(input int w);
    if (rst) begin
      m_busy = 1'b0; m_src = 2'd0; m_streak = 0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1'b1;
        m_src  = 2'(w);
      end
      if (w == 3) m_streak = 0;
      else if (w == 2 && dma_v) m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
      else if (!dma_v) m_streak = 0;
    end else if (op_done) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_gv got=%b want=0", grant_valid); end
    total++; if (grant_src !== 2'd0) begin bad++; $display("[TB] FAIL reset_src got=%0d want=0", grant_src); end
    total++; if (rdy !== 4'b0000) begin bad++; $display("[TB] FAIL reset_rdy got=%b want=0000", rdy); end
    total++; if (starve_active !== 1'b0) begin bad++; $display("[TB] FAIL reset_starve got=%b want=0", starve_active); end
  endtask

  task automatic test_priority();
    logic [3:0] mask;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      mask = 4'b1111 << k;
      next_cycle();
      drive(mask, 1'b1, 1'b0);
      #1;
      total++; if (rdy !== (4'b0001 << k)) begin bad++; $display("[TB] FAIL prio_rdy k=%0d got=%b want=%b", k, rdy, 4'b0001 << k); end
      next_cycle();
      drive(mask & ~(4'b0001 << k), 1'b1, 1'b1);
      #1;
      total++; if (grant_valid !== 1'b1 || grant_src !== 2'(k)) begin bad++; $display("[TB] FAIL prio_grant k=%0d got=%b/%0d want=1/%0d", k, grant_valid, grant_src, k); end
      total++; if (rdy !== 4'b0000) begin bad++; $display("[TB] FAIL prio_busy_rdy k=%0d got=%b want=0000", k, rdy); end
    end
  endtask

  task automatic test_hazard();
    do_reset();
    next_cycle();
    mshr_full = 1'b1;
    drive(4'b1100, 1'b1, 1'b0);
    #1;
    total++; if (rdy !== 4'b1000) begin bad++; $display("[TB] FAIL hazard_dma got=%b want=1000", rdy); end
    next_cycle();
    drive(4'b0100, 1'b1, 1'b1);
    #1;
    total++; if (grant_src !== 2'd3) begin bad++; $display("[TB] FAIL hazard_src got=%0d want=3", grant_src); end
    next_cycle();
    mshr_full = 1'b0;
    drive(4'b0100, 1'b1, 1'b0);
    #1;
    total++; if (rdy !== 4'b0100) begin bad++; $display("[TB] FAIL hazard_req got=%b want=0100", rdy); end
  endtask

  task automatic test_busy_hold();
    do_reset();
    next_cycle();
    drive(4'b0100, 1'b1, 1'b0);
    #1;
    total++; if (rdy !== 4'b0100) begin bad++; $display("[TB] FAIL hold_grant got=%b want=0100", rdy); end
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(4'($urandom), 1'($urandom), (i == 5) ? 1'b1 : 1'b0);
      {set_conflict, evict_stall, mshr_full} = 3'($urandom);
      #1;
      total++; if (rdy !== 4'b0000 || grant_valid !== 1'b1 || grant_src !== 2'd2) begin
        bad++; $display("[TB] FAIL hold_busy i=%0d got rdy=%b gv=%b src=%0d want 0000/1/2", i, rdy, grant_valid, grant_src);
      end
    end
    next_cycle();
    {set_conflict, evict_stall, mshr_full} = 3'b000;
    drive(4'b0100, 1'b1, 1'b0);
    #1;
    total++; if (rdy !== 4'b0100 || grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_turn got rdy=%b gv=%b want 0100/0", rdy, grant_valid); end
  endtask

  task automatic test_starvation();
    logic [3:0] want;
    logic       want_st;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(4'b1100, 1'b1, 1'b0);
      #1;
      want    = (STARVE_EN && (i % 3 == 2)) ? 4'b1000 : 4'b0100;
      want_st = STARVE_EN && (i % 3 == 2);
      total++; if (rdy !== want || starve_active !== want_st) begin
        bad++; $display("[TB] FAIL starve_seq i=%0d got rdy=%b st=%b want %b/%b", i, rdy, starve_active, want, want_st);
      end
      next_cycle();
      drive(4'b1100, 1'b1, 1'b1);
    end
  endtask

  task automatic test_rst_busy();
    do_reset();
    next_cycle();
    drive(4'b1100, 1'b1, 1'b0);
    next_cycle();
    rst = 1'b1;
    drive(4'b1111, 1'b1, 1'b0);
    #1;
    total++; if (rdy !== 4'b0000) begin bad++; $display("[TB] FAIL rstbusy_rdy got=%b want=0000", rdy); end
    next_cycle();
    rst = 1'b0;
    #1;
    total++; if (grant_valid !== 1'b0 || starve_active !== 1'b0) begin bad++; $display("[TB] FAIL rstbusy_drop got gv=%b st=%b want 0/0", grant_valid, starve_active); end
    total++; if (rdy !== 4'b0001) begin bad++; $display("[TB] FAIL rstbusy_prio got=%b want=0001", rdy); end
    next_cycle();
    drive(4'b1100, 1'b1, 1'b1);
    next_cycle();
    drive(4'b1100, 1'b1, 1'b0);
    #1;
    total++; if (rdy !== 4'b0100) begin bad++; $display("[TB] FAIL rstbusy_req1 got=%b want=0100", rdy); end
    next_cycle();
    drive(4'b1100, 1'b1, 1'b1);
    next_cycle();
    drive(4'b1100, 1'b1, 1'b0);
    #1;
    total++; if (rdy !== 4'b0100 || starve_active !== 1'b0) begin bad++; $display("[TB] FAIL rstbusy_cnt got rdy=%b st=%b want 0100/0", rdy, starve_active); end
  endtask

  task automatic test_no_decode();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(4'b1111, 1'b0, 1'b0);
      #1;
      total++; if (rdy !== 4'b0000 || grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL nodec i=%0d got rdy=%b gv=%b want 0000/0", i, rdy, grant_valid); end
    end
    next_cycle();
    drive(4'b1111, 1'b1, 1'b0);
    #1;
    total++; if (rdy !== 4'b0001) begin bad++; $display("[TB] FAIL nodec_release got=%b want=0001", rdy); end
  endtask

  task automatic test_random();
    int w;
    logic [3:0] want;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      rst = ($urandom_range(0, 39) == 0);
      drive(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      set_conflict = ($urandom_range(0, 4) == 0);
      evict_stall  = ($urandom_range(0, 5) == 0);
      mshr_full    = ($urandom_range(0, 5) == 0);
      #1;
      w    = model_winner();
      want = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      total++; if (rdy !== want) begin bad++; $display("[TB] FAIL rand_rdy i=%0d got=%b want=%b", i, rdy, want); end
      total++; if (grant_valid !== m_busy) begin bad++; $display("[TB] FAIL rand_gv i=%0d got=%b want=%b", i, grant_valid, m_busy); end
      total++; if (grant_src !== m_src) begin bad++; $display("[TB] FAIL rand_src i=%0d got=%0d want=%0d", i, grant_src, m_src); end
      total++; if (starve_active !== (STARVE_EN && m_streak >= LIMIT)) begin
        bad++; $display("[TB] FAIL rand_starve i=%0d got=%b want=%b", i, starve_active, STARVE_EN && m_streak >= LIMIT);
      end
      model_clock(w);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_hazard();
    test_busy_hold();
    test_starvation();
    test_rst_busy();
    test_no_decode();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
